// File: rtl/counter_fsm_pkg.sv
// Shared types and defaults for the counter_fsm up/down counter.
package counter_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UP       = 2'd1,
        ST_DOWN     = 2'd2,
        ST_OVERFLOW = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/counter_fsm.sv
// Up/down counter sequenced by a Moore FSM; a step past either end traps in a sticky OVERFLOW.
// Handshake: none -- act is a plain per-cycle enable sampled on every rising clk edge.
module counter_fsm
    import counter_fsm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             act,
    input  logic             up_down,
    input  logic             reset,
    input  logic             clk,
    output logic             overflow,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       dbg_state
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_overflow;

    state_t           w_next_state;
    logic [WIDTH-1:0] w_next_count;

    // act is tested before up_down so an unknown direction cannot leak in while holding.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        if (r_state == ST_OVERFLOW) begin
            w_next_state = ST_OVERFLOW;
        end else if (!act) begin
            w_next_state = ST_IDLE;
        end else if (up_down) begin
            if (r_count == MAX) begin
                w_next_state = ST_OVERFLOW;
            end else begin
                w_next_state = ST_UP;
                w_next_count = r_count + WIDTH'(1);
            end
        end else begin
            if (r_count == '0) begin
                w_next_state = ST_OVERFLOW;
            end else begin
                w_next_state = ST_DOWN;
                w_next_count = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_count    <= w_next_count;
            r_overflow <= (w_next_state == ST_OVERFLOW);
        end
    end

    assign overflow  = r_overflow;
    assign count     = r_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_counter_fsm.sv
// Directed checks of counter_fsm: reset, full-range count, underflow, hold, async reset, random walk.
module tb_counter_fsm;
    import counter_fsm_pkg::*;

    logic       clk;
    logic       reset;
    logic       act;
    logic       up_down;
    logic       overflow;
    logic [3:0] count;
    logic [1:0] dbg_state;

    int n_total = 0;
    int n_bad   = 0;

    logic [4:0] exp_q[$];
    logic [3:0] m_count;
    logic       m_ovf;

    counter_fsm #(.WIDTH(4)) dut (
        .act       (act),
        .up_down   (up_down),
        .reset     (reset),
        .clk       (clk),
        .overflow  (overflow),
        .count     (count),
        .dbg_state (dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // driver: apply inputs, let one rising edge pass, then settle 1 time unit past it
    task automatic tick(input logic a, input logic ud);
        act     = a;
        up_down = ud;
        @(posedge clk);
        #1;
    endtask

    // reset is pulsed between edges; outputs must clear with no clock edge
    task automatic pulse_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        #1;
        reset = 1'b0;
    endtask

    // reference model for the random walk
    task automatic model_step(input logic a, input logic ud);
        if (m_ovf) begin
            m_ovf = 1'b1;
        end else if (a) begin
            if (ud) begin
                if (m_count == 4'd15) m_ovf = 1'b1;
                else m_count = m_count + 4'd1;
            end else begin
                if (m_count == 4'd0) m_ovf = 1'b1;
                else m_count = m_count - 4'd1;
            end
        end
    endtask

    initial begin
        logic       ud;
        logic [4:0] exp_v;
        logic       was_ovf;

        act     = 1'b0;
        up_down = 1'b0;
        reset   = 1'b0;

        // reset asserted with no clock edge in between
        #2;
        reset = 1'b1;
        #1;
        check("init_count", 32'(count), 32'd0);
        check("init_ovf", 32'(overflow), 32'd0);
        check("init_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            check("idle_hold", 32'(count), 32'd0);
        end

        // count up through the full range, then trap
        pulse_reset();
        for (int i = 1; i <= 15; i++) begin
            tick(1'b1, 1'b1);
            check("up_count", 32'(count), 32'(i));
            check("up_ovf", 32'(overflow), 32'd0);
        end
        tick(1'b1, 1'b1);
        check("top_ovf", 32'(overflow), 32'd1);
        check("top_count", 32'(count), 32'd15);
        check("top_state", 32'(dbg_state), 32'(ST_OVERFLOW));
        tick(1'b0, 1'b0);
        check("sticky_a0_ovf", 32'(overflow), 32'd1);
        check("sticky_a0_count", 32'(count), 32'd15);
        tick(1'b1, 1'b0);
        check("sticky_dn_ovf", 32'(overflow), 32'd1);
        check("sticky_dn_count", 32'(count), 32'd15);

        // reset while trapped
        pulse_reset();

        // underflow on the very first step
        tick(1'b1, 1'b0);
        check("under_ovf", 32'(overflow), 32'd1);
        check("under_count", 32'(count), 32'd0);
        tick(1'b1, 1'b1);
        check("under_sticky_ovf", 32'(overflow), 32'd1);
        check("under_sticky_count", 32'(count), 32'd0);
        pulse_reset();
        check("post_rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // hold and direction change
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
        check("hd_up5", 32'(count), 32'd5);
        check("hd_up_state", 32'(dbg_state), 32'(ST_UP));
        tick(1'b0, 1'bx);
        tick(1'b0, 1'b1);
        check("hd_hold", 32'(count), 32'd5);
        check("hd_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        check("hd_down3", 32'(count), 32'd2);
        check("hd_down_state", 32'(dbg_state), 32'(ST_DOWN));
        tick(1'b1, 1'b1);
        check("hd_up1", 32'(count), 32'd3);
        check("hd_ovf", 32'(overflow), 32'd0);

        // async reset mid-count at 9
        pulse_reset();
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b1);
        check("mid_count9", 32'(count), 32'd9);
        pulse_reset();
        tick(1'b1, 1'b1);
        check("resume_count", 32'(count), 32'd1);

        // random walk against the model, starting from mid-range
        pulse_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
        m_count = 4'd8;
        m_ovf   = 1'b0;
        tick(1'b1, 1'b1);
        check("rw_start", 32'(count), 32'd8);
        for (int i = 0; i < 40; i++) begin
            ud      = 1'($urandom_range(0, 1));
            was_ovf = m_ovf;
            model_step(1'b1, ud);
            exp_q.push_back({m_ovf, m_count});
            tick(1'b1, ud);
            exp_v = exp_q.pop_front();
            check("rw_count", 32'(count), 32'(exp_v[3:0]));
            check("rw_ovf", 32'(overflow), 32'(exp_v[4]));
            if (was_ovf) check("rw_sticky", 32'(overflow), 32'd1);
        end
        pulse_reset();

        // final report
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
